alu_stage: RTL and testbench

ALU_STAGE -- requirements
Module: alu_stage

---
 rtl/alu_stage.sv | 150 +++++++++++++++
 tb/tb_alu_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_stage.sv
// alu_stage: one-deep ARM data-processing ALU stage with a valid/ready handshake.
// Result, destination, write enable and NZCV flags are all registered.
module alu_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic              s_bit,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic              shifter_carry,
  input  logic [3:0]        dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        out_dest,
  output logic              write_en,
  output logic [3:0]        flags
);

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  logic              valid_r;
  logic [DATA_W-1:0] result_r;
  logic [3:0]        dest_r;
  logic              we_r;
  logic [3:0]        flags_r;

  logic              accept_s;
  logic              compare_s;
  logic              arith_s;
  logic [DATA_W-1:0] opa_s;
  logic [DATA_W-1:0] opb_s;
  logic              cin_s;
  logic [DATA_W:0]   sum_s;
  logic              ovf_s;
  logic [DATA_W-1:0] alu_s;
  logic [3:0]        next_flags_s;

  assign in_ready  = !valid_r || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign compare_s = (opcode[3:2] == 2'b10);

  // Effective adder operands: subtraction is a + ~b + carry-in, reverse forms swap the operands.
  always_comb begin
    arith_s = 1'b1;
    opa_s   = op1;
    opb_s   = op2;
    cin_s   = 1'b0;
    case (opcode)
      OP_ADD, OP_CMN: begin
        opa_s = op1;  opb_s = op2;  cin_s = 1'b0;
      end
      OP_ADC: begin
        opa_s = op1;  opb_s = op2;  cin_s = flags_r[1];
      end
      OP_SUB, OP_CMP: begin
        opa_s = op1;  opb_s = ~op2; cin_s = 1'b1;
      end
      OP_SBC: begin
        opa_s = op1;  opb_s = ~op2; cin_s = flags_r[1];
      end
      OP_RSB: begin
        opa_s = op2;  opb_s = ~op1; cin_s = 1'b1;
      end
      OP_RSC: begin
        opa_s = op2;  opb_s = ~op1; cin_s = flags_r[1];
      end
      default: begin
        arith_s = 1'b0;
      end
    endcase
  end

  assign sum_s = {1'b0, opa_s} + {1'b0, opb_s} + {{DATA_W{1'b0}}, cin_s};
  assign ovf_s = (opa_s[DATA_W-1] == opb_s[DATA_W-1]) && (sum_s[DATA_W-1] != opa_s[DATA_W-1]);

  // Result selection for logical ops; every arithmetic op takes the low word of the sum.
  always_comb begin
    alu_s = sum_s[DATA_W-1:0];
    case (opcode)
      OP_AND, OP_TST: alu_s = op1 & op2;
      OP_EOR, OP_TEQ: alu_s = op1 ^ op2;
      OP_ORR:         alu_s = op1 | op2;
      OP_MOV:         alu_s = op2;
      OP_BIC:         alu_s = op1 & ~op2;
      OP_MVN:         alu_s = ~op2;
      default:        alu_s = sum_s[DATA_W-1:0];
    endcase
  end

  // Logical ops take C from the shifter and leave V alone.
  always_comb begin
    next_flags_s[3] = alu_s[DATA_W-1];
    next_flags_s[2] = (alu_s == {DATA_W{1'b0}});
    if (arith_s) begin
      next_flags_s[1] = sum_s[DATA_W];
      next_flags_s[0] = ovf_s;
    end else begin
      next_flags_s[1] = shifter_carry;
      next_flags_s[0] = flags_r[0];
    end
  end

  // Output register: reset wins, then accept, then consume; a stalled result holds.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_r  <= 1'b0;
      result_r <= {DATA_W{1'b0}};
      dest_r   <= 4'h0;
      we_r     <= 1'b0;
      flags_r  <= 4'h0;
    end else if (accept_s) begin
      valid_r  <= 1'b1;
      result_r <= alu_s;
      dest_r   <= dest;
      we_r     <= !compare_s;
      if (s_bit || compare_s) begin
        flags_r <= next_flags_s;
      end
    end else if (valid_r && out_ready) begin
      valid_r <= 1'b0;
    end
  end

  assign out_valid = valid_r;
  assign result    = result_r;
  assign out_dest  = dest_r;
  assign write_en  = we_r;
  assign flags     = flags_r;

endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: directed checks of the documented scenarios, then randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_alu_stage;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, s_bit, shifter_carry;
  logic        out_valid, out_ready, write_en;
  logic [3:0]  opcode, dest, out_dest, flags;
  logic [31:0] op1, op2, result;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  logic        m_valid  = 1'b0;
  logic [31:0] m_result = 32'h0;
  logic [3:0]  m_dest   = 4'h0;
  logic        m_we     = 1'b0;
  logic [3:0]  m_flags  = 4'h0;
  logic [35:0] ref_out;

  always #5 clk = ~clk;

  alu_stage #(.DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .s_bit(s_bit), .op1(op1), .op2(op2),
    .shifter_carry(shifter_carry), .dest(dest), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_dest(out_dest),
    .write_en(write_en), .flags(flags)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: true mathematical sums/differences; returns {N,Z,C,V, result}.
  function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] x,
                                          input logic [31:0] y, input logic c_in,
                                          input logic sc, input logic v_in);
    longint ux, uy, sx, sy, u, s, bo, ci;
    logic [31:0] res;
    logic c, v;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y);
    ci = c_in ? 64'sd1 : 64'sd0;
    bo = 64'sd1 - ci;
    u = 0; s = 0;
    c = sc; v = v_in;
    res = 32'h0;
    case (op)
      4'h0, 4'h8: res = x & y;
      4'h1, 4'h9: res = x ^ y;
      4'hC:       res = x | y;
      4'hD:       res = y;
      4'hE:       res = x & ~y;
      4'hF:       res = ~y;
      default: begin
        case (op)
          4'h4, 4'hB: begin u = ux + uy;      s = sx + sy;      end
          4'h5:       begin u = ux + uy + ci; s = sx + sy + ci; end
          4'h2, 4'hA: begin u = ux - uy;      s = sx - sy;      end
          4'h6:       begin u = ux - uy - bo; s = sx - sy - bo; end
          4'h3:       begin u = uy - ux;      s = sy - sx;      end
          default:    begin u = uy - ux - bo; s = sy - sx - bo; end
        endcase
        res = u[31:0];
        if (op == 4'h4 || op == 4'h5 || op == 4'hB) c = (u >= 64'sh1_0000_0000);
        else c = (u >= 0);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
    endcase
    return {res[31], (res == 32'h0), c, v, res};
  endfunction

  always_comb ref_out = alu_ref(opcode, op1, op2, m_flags[1], shifter_carry, m_flags[0]);

  // Model state update at each rising edge.
  always @(posedge clk) begin
    if (!reset_n) begin
      m_valid <= 1'b0; m_result <= 32'h0; m_dest <= 4'h0; m_we <= 1'b0; m_flags <= 4'h0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid  <= 1'b1;
      m_result <= ref_out[31:0];
      m_dest   <= dest;
      m_we     <= !(opcode >= 4'h8 && opcode <= 4'hB);
      if (s_bit || (opcode >= 4'h8 && opcode <= 4'hB)) m_flags <= ref_out[35:32];
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("in_ready",  {31'b0, in_ready},  {31'b0, (!m_valid || out_ready)});
      chk("result",    result, m_result);
      chk("out_dest",  {28'b0, out_dest}, {28'b0, m_dest});
      chk("write_en",  {31'b0, write_en}, {31'b0, m_we});
      chk("flags",     {28'b0, flags},    {28'b0, m_flags});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input logic [3:0] op, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic sc);
    in_valid = 1'b1; opcode = op; s_bit = s; op1 = a; op2 = b; shifter_carry = sc;
    dest = dest + 4'h1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; opcode = 4'h0; s_bit = 1'b0;
    op1 = 32'h0; op2 = 32'h0; shifter_carry = 1'b0; dest = 4'h2;
    cyc(); cyc();
    chk_on = 1'b1;
    reset_n = 1'b1;
    cyc();
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {28'b0, flags}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

    setop(4'h4, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0); cyc();
    chk("adds_ovf_valid", {31'b0, out_valid}, 32'h1);
    chk("adds_ovf_result", result, 32'h8000_0000);
    chk("adds_ovf_flags", {28'b0, flags}, 32'h9);
    chk("adds_ovf_dest", {28'b0, out_dest}, 32'h3);

    setop(4'h2, 1'b1, 32'h5, 32'h5, 1'b0); cyc();
    chk("subs_eq_result", result, 32'h0);
    chk("subs_eq_flags", {28'b0, flags}, 32'h6);
    chk("subs_eq_we", {31'b0, write_en}, 32'h1);
    setop(4'hA, 1'b0, 32'h3, 32'h4, 1'b0); cyc();
    chk("cmp_result", result, 32'hFFFF_FFFF);
    chk("cmp_we", {31'b0, write_en}, 32'h0);
    chk("cmp_flags", {28'b0, flags}, 32'h8);

    setop(4'h4, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0); cyc();
    chk("adds_carry_flags", {28'b0, flags}, 32'h6);
    setop(4'h5, 1'b0, 32'h1, 32'h1, 1'b0); cyc();
    chk("adc_result", result, 32'h3);
    chk("adc_flags_hold", {28'b0, flags}, 32'h6);

    setop(4'h4, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0); cyc();
    setop(4'hD, 1'b1, 32'h1234_5678, 32'h8000_0000, 1'b1); cyc();
    chk("movs_result", result, 32'h8000_0000);
    chk("movs_flags", {28'b0, flags}, 32'hB);

    out_ready = 1'b0;
    setop(4'h4, 1'b1, 32'h1, 32'h1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
      chk("stall_result", result, 32'h8000_0000);
      chk("stall_flags", {28'b0, flags}, 32'hB);
    end
    out_ready = 1'b1; #1;
    chk("release_in_ready", {31'b0, in_ready}, 32'h1);
    cyc();
    chk("release_valid", {31'b0, out_valid}, 32'h1);
    chk("release_result", result, 32'h2);
    chk("release_flags", {28'b0, flags}, 32'h0);

    setop(4'h4, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0); cyc();
    setop(4'hD, 1'b1, 32'h0, 32'h8000_0000, 1'b1); cyc();
    out_ready = 1'b0; reset_n = 1'b0;
    setop(4'hF, 1'b1, 32'h0, 32'h0, 1'b1); cyc();
    chk("midrst_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_flags", {28'b0, flags}, 32'h0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'h1);

    for (int i = 0; i < 3000; i++) begin
      reset_n       = ($urandom_range(0, 99) != 0);
      in_valid      = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      opcode        = 4'($urandom_range(0, 15));
      s_bit         = 1'($urandom_range(0, 1));
      shifter_carry = 1'($urandom_range(0, 1));
      dest          = 4'($urandom_range(0, 15));
      op1           = pick();
      op2           = pick();
      cyc();
    end

    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
